// File: rtl/ram_fifo_ctrl.sv
// FIFO controller in front of an external simple dual-port RAM (sync write,
// async read). Holds pointers, occupancy and flags; head word falls through.
module ram_fifo_ctrl #(
  parameter int DATA_WIDTH    = 8,
  parameter int DATA_DEPTH    = 128,
  parameter int ADDR_WIDTH    = $clog2(DATA_DEPTH),
  parameter int AFULL_THRESH  = DATA_DEPTH - 4,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  almost_full,
  output logic                  almost_empty
);
  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0]         DEPTH_C  = CW'(DATA_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_C   = ADDR_WIDTH'(DATA_DEPTH - 1);
  localparam logic [CW-1:0]         AFULL_C  = CW'(AFULL_THRESH);
  localparam logic [CW-1:0]         AEMPTY_C = CW'(AEMPTY_THRESH);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  full, empty, wr_fire, rd_fire;

  // Handshake flags come from the registered count only, so s_ready never
  // depends on m_ready and a full FIFO cannot write through.
  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == '0);
  assign s_ready = !full;
  assign m_valid = !empty;
  assign wr_fire = s_valid & s_ready & !flush;
  assign rd_fire = m_valid & m_ready & !flush;

  assign ram_wr_en    = wr_fire;
  assign ram_wr_addr  = wr_ptr_q;
  assign ram_wr_data  = s_data;
  assign ram_rd_addr  = rd_ptr_q;
  assign m_data       = ram_rd_data;
  assign count        = count_q;
  assign almost_full  = (count_q >= AFULL_C);
  assign almost_empty = (count_q <= AEMPTY_C);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Explicit wrap so non-power-of-two depths work.
      if (wr_fire) wr_ptr_d = (wr_ptr_q == LAST_C) ? '0 : wr_ptr_q + ADDR_WIDTH'(1);
      if (rd_fire) rd_ptr_d = (rd_ptr_q == LAST_C) ? '0 : rd_ptr_q + ADDR_WIDTH'(1);
      case ({wr_fire, rd_fire})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    assert (DATA_DEPTH >= 2 && AFULL_THRESH <= DATA_DEPTH)
      else $error("ram_fifo_ctrl: illegal configuration (DATA_DEPTH < 2 or AFULL_THRESH > DATA_DEPTH)");
  end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl: two instances (depth 128 and depth 5) each backed by
// a behavioural RAM, checked against queue-based reference models.
module tb_ram_fifo_ctrl;
  localparam int D  = 128;
  localparam int D2 = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  int         checks = 0;
  int         errors = 0;

  // depth-128 instance
  logic       flush = 1'b0, s_valid = 1'b0, m_ready = 1'b0;
  logic [7:0] s_data = '0;
  logic       s_ready, m_valid, ram_wr_en, almost_full, almost_empty;
  logic [7:0] m_data, ram_wr_data, ram_rd_data;
  logic [6:0] ram_wr_addr, ram_rd_addr;
  logic [7:0] count;
  logic [7:0] ram_a [0:D-1];

  // depth-5 instance
  logic       flush2 = 1'b0, s_valid2 = 1'b0, m_ready2 = 1'b0;
  logic [7:0] s_data2 = '0;
  logic       s_ready2, m_valid2, ram_wr_en2, almost_full2, almost_empty2;
  logic [7:0] m_data2, ram_wr_data2, ram_rd_data2;
  logic [2:0] ram_wr_addr2, ram_rd_addr2;
  logic [3:0] count2;
  logic [7:0] ram_b [0:D2-1];

  // reference models: queue contents plus slot indices as modular counts
  logic [7:0] mq[$];
  logic [7:0] mq2[$];
  int wa = 0, ra = 0, wa2 = 0, ra2 = 0;

  always #5 clk = ~clk;

  ram_fifo_ctrl #(.DATA_WIDTH(8), .DATA_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
    .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
    .count(count), .almost_full(almost_full), .almost_empty(almost_empty)
  );

  ram_fifo_ctrl #(.DATA_WIDTH(8), .DATA_DEPTH(D2)) dut2 (
    .clk(clk), .rst(rst), .flush(flush2),
    .s_valid(s_valid2), .s_ready(s_ready2), .s_data(s_data2),
    .m_valid(m_valid2), .m_ready(m_ready2), .m_data(m_data2),
    .ram_wr_en(ram_wr_en2), .ram_wr_addr(ram_wr_addr2), .ram_wr_data(ram_wr_data2),
    .ram_rd_addr(ram_rd_addr2), .ram_rd_data(ram_rd_data2),
    .count(count2), .almost_full(almost_full2), .almost_empty(almost_empty2)
  );

  always @(posedge clk) begin
    if (ram_wr_en)  ram_a[ram_wr_addr]  <= ram_wr_data;
    if (ram_wr_en2) ram_b[ram_wr_addr2] <= ram_wr_data2;
  end
  assign ram_rd_data  = ram_a[ram_rd_addr];
  assign ram_rd_data2 = ram_b[ram_rd_addr2];

  task automatic tick();
    bit ew, er;
    logic [7:0] d;
    er = m_ready && !flush && mq.size() > 0;
    ew = s_valid && !flush && mq.size() < D;
    d  = s_data;
    @(posedge clk);
    if (flush) begin
      mq.delete(); wa = 0; ra = 0;
    end else begin
      if (er) begin void'(mq.pop_front()); ra = (ra + 1) % D; end
      if (ew) begin mq.push_back(d); wa = (wa + 1) % D; end
    end
    #1;
  endtask

  task automatic tick2();
    bit ew, er;
    logic [7:0] d;
    er = m_ready2 && !flush2 && mq2.size() > 0;
    ew = s_valid2 && !flush2 && mq2.size() < D2;
    d  = s_data2;
    @(posedge clk);
    if (flush2) begin
      mq2.delete(); wa2 = 0; ra2 = 0;
    end else begin
      if (er) begin void'(mq2.pop_front()); ra2 = (ra2 + 1) % D2; end
      if (ew) begin mq2.push_back(d); wa2 = (wa2 + 1) % D2; end
    end
    #1;
  endtask

  task automatic drain_main();
    int n = 0;
    s_valid = 1'b0; m_ready = 1'b1;
    while (mq.size() > 0 && n < 300) begin tick(); n++; end
    m_ready = 1'b0;
    #1;
    checks++; if (count !== 8'd0) begin errors++; $display("FAIL drain_empty: got %0d, expected 0", count); end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (count !== 8'd0)    begin errors++; $display("FAIL rst_count: got %0d, expected 0", count); end
    checks++; if (m_valid !== 1'b0)  begin errors++; $display("FAIL rst_m_valid: got %0b, expected 0", m_valid); end
    checks++; if (s_ready !== 1'b1)  begin errors++; $display("FAIL rst_s_ready: got %0b, expected 1", s_ready); end
    checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL rst_aempty: got %0b, expected 1", almost_empty); end
    checks++; if (almost_full !== 1'b0)  begin errors++; $display("FAIL rst_afull: got %0b, expected 0", almost_full); end
    checks++; if (ram_wr_en !== 1'b0)    begin errors++; $display("FAIL rst_wr_en: got %0b, expected 0", ram_wr_en); end
    checks++; if (ram_wr_addr !== 7'd0 || ram_rd_addr !== 7'd0) begin errors++; $display("FAIL rst_addr: got wr %0d rd %0d, expected 0 0", ram_wr_addr, ram_rd_addr); end
    #2 rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (count !== 8'd0 || m_valid !== 1'b0 || count2 !== 4'd0) begin errors++; $display("FAIL idle_after_rst: got count %0d m_valid %0b count2 %0d, expected 0 0 0", count, m_valid, count2); end
  endtask

  task automatic test_fill();
    m_ready = 1'b0;
    for (int i = 0; i < D; i++) begin
      s_valid = 1'b1; s_data = 8'(i + 1);
      #1;
      checks++; if (ram_wr_en !== 1'b1) begin errors++; $display("FAIL fill_wr_en: got %0b, expected 1 at word %0d", ram_wr_en, i); end
      checks++; if (ram_wr_addr !== 7'(i)) begin errors++; $display("FAIL fill_wr_addr: got %0d, expected %0d", ram_wr_addr, i); end
      checks++; if (count !== 8'(i)) begin errors++; $display("FAIL fill_count: got %0d, expected %0d", count, i); end
      checks++; if (almost_full !== (i >= 124)) begin errors++; $display("FAIL fill_afull: got %0b, expected %0b at count %0d", almost_full, (i >= 124), i); end
      checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL fill_s_ready: got %0b, expected 1 at count %0d", s_ready, i); end
      tick();
    end
    s_data = 8'h99;
    #1;
    checks++; if (s_ready !== 1'b0)   begin errors++; $display("FAIL full_s_ready: got %0b, expected 0", s_ready); end
    checks++; if (ram_wr_en !== 1'b0) begin errors++; $display("FAIL full_wr_en: got %0b, expected 0", ram_wr_en); end
    checks++; if (count !== 8'd128)   begin errors++; $display("FAIL full_count: got %0d, expected 128", count); end
    tick();
    checks++; if (count !== 8'd128 || mq.size() != D) begin errors++; $display("FAIL full_hold: got %0d, expected 128", count); end
    s_valid = 1'b0;
  endtask

  task automatic test_drain();
    s_valid = 1'b0; m_ready = 1'b1;
    for (int i = 0; i < D; i++) begin
      #1;
      checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL drain_m_valid: got %0b, expected 1 at read %0d", m_valid, i); end
      checks++; if (m_data !== 8'(i + 1)) begin errors++; $display("FAIL drain_data: got %0h, expected %0h", m_data, 8'(i + 1)); end
      checks++; if (ram_rd_addr !== 7'(i)) begin errors++; $display("FAIL drain_rd_addr: got %0d, expected %0d", ram_rd_addr, i); end
      tick();
    end
    #1;
    checks++; if (m_valid !== 1'b0)    begin errors++; $display("FAIL drain_m_valid_end: got %0b, expected 0", m_valid); end
    checks++; if (ram_rd_addr !== 7'd0) begin errors++; $display("FAIL drain_rd_wrap: got %0d, expected 0", ram_rd_addr); end
    checks++; if (count !== 8'd0 || almost_empty !== 1'b1) begin errors++; $display("FAIL drain_count: got %0d ae %0b, expected 0 1", count, almost_empty); end
    m_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] sent[$];
    logic [7:0] base;
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1; s_data = 8'($urandom); sent.push_back(s_data);
      tick();
    end
    base = 8'($urandom);
    m_ready = 1'b1;
    for (int k = 0; k < 300; k++) begin
      s_data = base + 8'(k); sent.push_back(s_data);
      #1;
      checks++; if (count !== 8'd3) begin errors++; $display("FAIL b2b_count: got %0d, expected 3 at cycle %0d", count, k); end
      checks++; if (m_data !== sent[k]) begin errors++; $display("FAIL b2b_data: got %0h, expected %0h at cycle %0d", m_data, sent[k], k); end
      checks++; if (ram_wr_addr !== 7'(wa) || ram_rd_addr !== 7'(ra)) begin errors++; $display("FAIL b2b_addr: got wr %0d rd %0d, expected %0d %0d", ram_wr_addr, ram_rd_addr, wa, ra); end
      tick();
    end
    drain_main();
  endtask

  task automatic test_fallthrough();
    s_valid = 1'b1; m_ready = 1'b1; s_data = 8'hA5;
    #1;
    checks++; if (ram_wr_en !== 1'b1 || m_valid !== 1'b0) begin errors++; $display("FAIL ft_write_only: got wr_en %0b m_valid %0b, expected 1 0", ram_wr_en, m_valid); end
    tick();
    s_valid = 1'b0;
    #1;
    checks++; if (m_valid !== 1'b1 || m_data !== 8'hA5) begin errors++; $display("FAIL ft_visible: got m_valid %0b data %0h, expected 1 a5", m_valid, m_data); end
    tick();
    checks++; if (count !== 8'd0 || m_valid !== 1'b0) begin errors++; $display("FAIL ft_consumed: got count %0d m_valid %0b, expected 0 0", count, m_valid); end
    m_ready = 1'b0;
  endtask

  task automatic test_flush();
    m_ready = 1'b0;
    for (int i = 0; i < 50; i++) begin s_valid = 1'b1; s_data = 8'($urandom); tick(); end
    flush = 1'b1; s_valid = 1'b1; m_ready = 1'b1;
    #1;
    checks++; if (ram_wr_en !== 1'b0) begin errors++; $display("FAIL flush_wr_en: got %0b, expected 0", ram_wr_en); end
    checks++; if (count !== 8'd50)    begin errors++; $display("FAIL flush_pre_count: got %0d, expected 50", count); end
    tick();
    flush = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
    #1;
    checks++; if (count !== 8'd0 || m_valid !== 1'b0) begin errors++; $display("FAIL flush_clear: got count %0d m_valid %0b, expected 0 0", count, m_valid); end
    checks++; if (ram_wr_addr !== 7'd0 || ram_rd_addr !== 7'd0) begin errors++; $display("FAIL flush_addr: got wr %0d rd %0d, expected 0 0", ram_wr_addr, ram_rd_addr); end
  endtask

  task automatic test_async_reset();
    logic [7:0] d;
    m_ready = 1'b0;
    for (int i = 0; i < 70; i++) begin s_valid = 1'b1; s_data = 8'($urandom); tick(); end
    #1;
    checks++; if (count !== 8'd70) begin errors++; $display("FAIL arst_pre_count: got %0d, expected 70", count); end
    #1 rst = 1'b1;
    #1;
    checks++; if (count !== 8'd0 || m_valid !== 1'b0) begin errors++; $display("FAIL arst_immediate: got count %0d m_valid %0b, expected 0 0", count, m_valid); end
    checks++; if (ram_wr_addr !== 7'd0 || ram_rd_addr !== 7'd0) begin errors++; $display("FAIL arst_ptrs: got wr %0d rd %0d, expected 0 0", ram_wr_addr, ram_rd_addr); end
    s_valid = 1'b0;
    mq.delete(); wa = 0; ra = 0;
    mq2.delete(); wa2 = 0; ra2 = 0;
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    d = 8'($urandom);
    s_valid = 1'b1; s_data = d;
    #1;
    checks++; if (ram_wr_en !== 1'b1 || ram_wr_addr !== 7'd0) begin errors++; $display("FAIL arst_first_addr: got wr_en %0b addr %0d, expected 1 0", ram_wr_en, ram_wr_addr); end
    tick();
    s_valid = 1'b0;
    #1;
    checks++; if (m_valid !== 1'b1 || m_data !== d || count !== 8'd1) begin errors++; $display("FAIL arst_first_word: got v %0b data %0h count %0d, expected 1 %0h 1", m_valid, m_data, count, d); end
    drain_main();
  endtask

  task automatic test_random();
    int pw;
    for (int p = 0; p < 6; p++) begin
      pw = (p % 2 == 0) ? 85 : 25;
      for (int c = 0; c < 400; c++) begin
        s_valid = ($urandom_range(99) < pw);
        m_ready = ($urandom_range(99) < 100 - pw);
        flush   = ($urandom_range(499) == 0);
        s_data  = 8'($urandom);
        #1;
        checks++; if (count !== 8'(mq.size())) begin errors++; $display("FAIL rnd_count: got %0d, expected %0d", count, mq.size()); end
        checks++; if (m_valid !== (mq.size() > 0) || s_ready !== (mq.size() < D)) begin errors++; $display("FAIL rnd_flags: got v %0b r %0b, expected size %0d", m_valid, s_ready, mq.size()); end
        checks++; if (almost_full !== (mq.size() >= D - 4) || almost_empty !== (mq.size() <= 4)) begin errors++; $display("FAIL rnd_almost: got af %0b ae %0b, expected size %0d", almost_full, almost_empty, mq.size()); end
        checks++; if (ram_wr_en !== (s_valid && !flush && mq.size() < D)) begin errors++; $display("FAIL rnd_wr_en: got %0b, expected size %0d flush %0b", ram_wr_en, mq.size(), flush); end
        checks++; if (ram_wr_addr !== 7'(wa) || ram_rd_addr !== 7'(ra)) begin errors++; $display("FAIL rnd_addr: got wr %0d rd %0d, expected %0d %0d", ram_wr_addr, ram_rd_addr, wa, ra); end
        if (mq.size() > 0) begin
          checks++; if (m_data !== mq[0]) begin errors++; $display("FAIL rnd_data: got %0h, expected %0h", m_data, mq[0]); end
        end
        tick();
      end
    end
    flush = 1'b0;
    drain_main();
  endtask

  task automatic test_small_interleave();
    logic [7:0] d;
    for (int i = 0; i < 12; i++) begin
      d = 8'($urandom);
      s_valid2 = 1'b1; s_data2 = d;
      #1;
      checks++; if (ram_wr_en2 !== 1'b1 || ram_wr_addr2 !== 3'(i % 5)) begin errors++; $display("FAIL d5_wr_addr: got en %0b addr %0d, expected 1 %0d", ram_wr_en2, ram_wr_addr2, i % 5); end
      tick2();
      s_valid2 = 1'b0; m_ready2 = 1'b1;
      #1;
      checks++; if (ram_rd_addr2 !== 3'(i % 5)) begin errors++; $display("FAIL d5_rd_addr: got %0d, expected %0d", ram_rd_addr2, i % 5); end
      checks++; if (m_valid2 !== 1'b1 || m_data2 !== d) begin errors++; $display("FAIL d5_data: got v %0b data %0h, expected 1 %0h", m_valid2, m_data2, d); end
      tick2();
      m_ready2 = 1'b0;
    end
  endtask

  task automatic test_small_random();
    for (int c = 0; c < 400; c++) begin
      s_valid2 = ($urandom_range(99) < ((c / 50) % 2 == 0 ? 80 : 30));
      m_ready2 = ($urandom_range(99) < ((c / 50) % 2 == 0 ? 30 : 80));
      flush2   = ($urandom_range(199) == 0);
      s_data2  = 8'($urandom);
      #1;
      checks++; if (count2 !== 4'(mq2.size()) || s_ready2 !== (mq2.size() < D2)) begin errors++; $display("FAIL d5_rnd_count: got %0d ready %0b, expected %0d", count2, s_ready2, mq2.size()); end
      checks++; if (almost_full2 !== (mq2.size() >= 1) || almost_empty2 !== (mq2.size() <= 4)) begin errors++; $display("FAIL d5_rnd_almost: got af %0b ae %0b, expected size %0d", almost_full2, almost_empty2, mq2.size()); end
      checks++; if (ram_wr_addr2 !== 3'(wa2) || ram_rd_addr2 !== 3'(ra2)) begin errors++; $display("FAIL d5_rnd_addr: got wr %0d rd %0d, expected %0d %0d", ram_wr_addr2, ram_rd_addr2, wa2, ra2); end
      if (mq2.size() > 0) begin
        checks++; if (m_data2 !== mq2[0]) begin errors++; $display("FAIL d5_rnd_data: got %0h, expected %0h", m_data2, mq2[0]); end
      end
      tick2();
    end
    flush2 = 1'b0; s_valid2 = 1'b0; m_ready2 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_fallthrough();
    test_flush();
    test_async_reset();
    test_random();
    test_small_interleave();
    test_small_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ram_fifo_ctrl.md
Name: ram_fifo_ctrl

Overview:
- Synchronous FIFO controller that sits directly in front of the team's simple dual-port RAM (DATA_WIDTH x DATA_DEPTH, one synchronous write port, one asynchronous read port).
- Owns the write and read pointers, the occupancy count and the flags.
- Drives the RAM write port from an upstream valid/ready stream.
- Presents RAM read data to a downstream valid/ready stream as first-word-fall-through.
- The RAM itself stays external; this block holds no data storage.

Parameters:
- DATA_WIDTH, 8, stream and RAM data width.
- DATA_DEPTH, 128, number of RAM entries; need not be a power of two.
- ADDR_WIDTH, $clog2(DATA_DEPTH), RAM address width.
- AFULL_THRESH, DATA_DEPTH-4, almost_full asserts when count >= this value.
- AEMPTY_THRESH, 4, almost_empty asserts when count <= this value.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous, active-high.
- flush  input  1  synchronous clear of all FIFO contents.
- s_valid  input  1  upstream word present.
- s_ready  output  1  FIFO can accept a word.
- s_data  input  DATA_WIDTH  upstream word.
- m_valid  output  1  head word present.
- m_ready  input  1  downstream consumes the head word.
- m_data  output  DATA_WIDTH  head word.
- ram_wr_en  output  1  RAM write enable.
- ram_wr_addr  output  ADDR_WIDTH  RAM write address.
- ram_wr_data  output  DATA_WIDTH  RAM write data.
- ram_rd_addr  output  ADDR_WIDTH  RAM read address.
- ram_rd_data  input  DATA_WIDTH  RAM asynchronous read data.
- count  output  ADDR_WIDTH+1  current occupancy, 0..DATA_DEPTH.
- almost_full  output  1  count >= AFULL_THRESH.
- almost_empty  output  1  count <= AEMPTY_THRESH.

Behaviour:
- Reset (rst high, asynchronous, any time, including mid-transfer):
  - wr_ptr, rd_ptr and count go to 0 immediately.
  - Resulting outputs: m_valid 0, s_ready 1, almost_full 0, almost_empty 1, ram_wr_en 0 (when s_valid is low), ram_wr_addr 0, ram_rd_addr 0.
  - RAM contents are not cleared and are treated as stale.
- Full and empty:
  - full = (count == DATA_DEPTH); empty = (count == 0).
  - s_ready = !full and m_valid = !empty, both combinational from registered count only.
  - s_ready does not depend on m_ready: no write-through when full.
- Fire conditions: wr_fire = s_valid & s_ready & !flush; rd_fire = m_valid & m_ready & !flush.
- RAM write port:
  - ram_wr_en = wr_fire; ram_wr_addr = wr_ptr; ram_wr_data = s_data, all combinational.
  - The RAM captures the word on the same edge that advances wr_ptr.
- RAM read port: ram_rd_addr = rd_ptr; m_data = ram_rd_data, combinational, zero added latency.
- Pointer advance: on wr_fire wr_ptr advances, and on rd_fire rd_ptr advances. Each wraps explicitly from DATA_DEPTH-1 to 0; no power-of-two assumption.
- Count update:
  - +1 on wr_fire only; -1 on rd_fire only.
  - Unchanged when both fire in the same cycle; both pointers still advance.
- Latency:
  - A word written at edge N is visible on m_data with m_valid high in the cycle after edge N (one-cycle fall-through).
  - When empty, a simultaneous s_valid and m_ready produces a write only.
- Flush:
  - Synchronous; takes priority over both fires.
  - At the edge it clears wr_ptr, rd_ptr and count to 0.
  - During the flush cycle, ram_wr_en is 0 and no handshake completes, even if s_ready and m_valid are high.
- Almost flags: combinational compares on count; both thresholds are inclusive.
- Illegal configurations (checked only by simulation assertion):
  - DATA_DEPTH < 2.
  - AFULL_THRESH > DATA_DEPTH.

Test Plan:
- Reset then idle, DATA_DEPTH=128 → count=0, m_valid=0, s_ready=1, almost_empty=1, almost_full=0, ram_wr_en=0.
- Write 0x01..0x80 (128 words) with m_ready=0:
  - ram_wr_addr steps 0..127;
  - almost_full rises when count reaches 124;
  - s_ready falls when count reaches 128;
  - a 129th s_valid is held off with no ram_wr_en.
- Then m_ready=1, s_valid=0 → m_data reads 0x01..0x80 in order; rd_ptr wraps 127→0; m_valid falls after the 128th read.
- Fill to 3, then s_valid=1 and m_ready=1 continuously for 300 cycles with incrementing data:
  - count stays 3;
  - the output sequence equals the input sequence delayed by 3 words;
  - both pointers wrap without error.
- When empty, write 0xA5 at edge N → m_valid=1 and m_data=0xA5 in the cycle after N; if m_ready is high in that cycle, count returns to 0.
- Fill to 50, then assert flush with s_valid=1 and m_ready=1 → ram_wr_en=0 in that cycle; next cycle count=0, m_valid=0, ram_wr_addr=0, ram_rd_addr=0.
- Assert rst asynchronously mid-burst at count=70, between clock edges → count, m_valid and the pointers drop immediately; after release, the first new word is written to address 0.
- DATA_DEPTH=5 configuration: 12 writes and 12 reads interleaved → addresses cycle 0,1,2,3,4,0,…; data order preserved.
